// File: rtl/gb_cpu_pkg.sv
// gb_cpu_pkg: shared register-file indices, pair codes and write-port constants
package gb_cpu_pkg;
  localparam logic [2:0] REG_B = 3'd0;
  localparam logic [2:0] REG_C = 3'd1;
  localparam logic [2:0] REG_D = 3'd2;
  localparam logic [2:0] REG_E = 3'd3;
  localparam logic [2:0] REG_H = 3'd4;
  localparam logic [2:0] REG_L = 3'd5;
  localparam logic [2:0] REG_A = 3'd6;
  localparam logic [2:0] REG_F = 3'd7;
  localparam logic [1:0] PAIR_BC = 2'd0;
  localparam logic [1:0] PAIR_DE = 2'd1;
  localparam logic [1:0] PAIR_HL = 2'd2;
  localparam logic [1:0] PAIR_AF = 2'd3;
  localparam int NUM_WR_REQ = 3;
  localparam logic [7:0] F_LOW_MASK = 8'hF0;
endpackage

// File: rtl/round_robin_pick.sv
// round_robin_pick: combinational 3-way round-robin winner search starting at i_Ptr
module round_robin_pick (
  input  logic [2:0] i_Req,
  input  logic [1:0] i_Ptr,
  output logic [2:0] o_Win,
  output logic       o_Valid
);
  logic [2:0] w_Rot, w_First;
  always_comb begin
    w_Rot   = i_Ptr == 2'd1 ? {i_Req[0], i_Req[2:1]} :
              i_Ptr == 2'd2 ? {i_Req[1:0], i_Req[2]} : i_Req;
    w_First = w_Rot & (~w_Rot + 3'd1);
    o_Win   = i_Ptr == 2'd1 ? {w_First[1:0], w_First[2]} :
              i_Ptr == 2'd2 ? {w_First[0], w_First[2:1]} : w_First;
    o_Valid = |i_Req;
  end
endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin scheduler of ALU/load/IDU writes onto one registered register-file write port
module regfile_write_arbiter
  import gb_cpu_pkg::*;
(
  input  logic                    i_Clk,
  input  logic                    i_nRst,
  input  logic                    i_Enable,
  input  logic [NUM_WR_REQ-1:0]   i_Req,
  input  logic [NUM_WR_REQ-1:0]   i_Wide,
  input  logic [3*NUM_WR_REQ-1:0] i_Addr,
  input  logic [16*NUM_WR_REQ-1:0] i_Data,
  output logic [NUM_WR_REQ-1:0]   o_Gnt,
  output logic [7:0]              o_WrEn,
  output logic [7:0]              o_WrHi,
  output logic [7:0]              o_WrLo,
  output logic                    o_Busy
);
  logic [1:0] r_Ptr, w_Idx, w_NextPtr;
  logic [2:0] r_Gnt, w_Win, w_Addr;
  logic [7:0] r_WrEn, r_WrHi, r_WrLo, w_WrEn, w_Hi, w_Lo;
  logic [15:0] w_Data;
  logic r_Busy, w_Valid, w_Wide;

  round_robin_pick u_pick (
    .i_Req  (i_Req),
    .i_Ptr  (r_Ptr),
    .o_Win  (w_Win),
    .o_Valid(w_Valid)
  );

  always_comb begin
    w_Idx     = w_Win[2] ? 2'd2 : w_Win[1] ? 2'd1 : 2'd0;
    w_Addr    = i_Addr[3*w_Idx +: 3];
    w_Wide    = i_Wide[w_Idx];
    w_Data    = i_Data[16*w_Idx +: 16];
    // pair writes ignore the low address bit and strobe both halves
    w_WrEn    = w_Wide ? 8'b11 << {w_Addr[2:1], 1'b0} : 8'b1 << w_Addr;
    w_Hi      = w_Wide ? w_Data[15:8] : w_Data[7:0];
    w_Lo      = w_WrEn[REG_F] ? w_Data[7:0] & F_LOW_MASK : w_Data[7:0];
    w_NextPtr = w_Idx == 2'd2 ? 2'd0 : w_Idx + 2'd1;
  end

  always_ff @(posedge i_Clk or negedge i_nRst)
    if (!i_nRst) begin
      r_Ptr  <= '0;
      r_Gnt  <= '0;
      r_WrEn <= '0;
      r_WrHi <= '0;
      r_WrLo <= '0;
      r_Busy <= 1'b0;
    end else if (i_Enable) begin
      r_Gnt  <= w_Win;
      r_WrEn <= w_Valid ? w_WrEn : '0;
      r_Busy <= |i_Req;
      if (w_Valid) begin
        r_Ptr  <= w_NextPtr;
        r_WrHi <= w_Hi;
        r_WrLo <= w_Lo;
      end
    end else begin
      r_Gnt  <= '0;
      r_WrEn <= '0;
    end

  assign o_Gnt  = r_Gnt;
  assign o_WrEn = r_WrEn;
  assign o_WrHi = r_WrHi;
  assign o_WrLo = r_WrLo;
  assign o_Busy = r_Busy;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed stimulus with a queued scoreboard checked on every granted cycle
module tb_regfile_write_arbiter;
  typedef struct packed {
    logic [2:0] g;
    logic [7:0] en;
    logic [7:0] hi;
    logic [7:0] lo;
  } exp_t;

  logic i_Clk = 1'b0, i_nRst = 1'b0, i_Enable = 1'b1;
  logic [2:0] i_Req = '0, i_Wide = '0;
  logic [8:0] i_Addr = '0;
  logic [47:0] i_Data = '0;
  logic [2:0] o_Gnt;
  logic [7:0] o_WrEn, o_WrHi, o_WrLo;
  logic o_Busy;
  exp_t q[$];
  exp_t e;
  int n_cmp = 0, n_bad = 0;

  regfile_write_arbiter dut (
    .i_Clk   (i_Clk),
    .i_nRst  (i_nRst),
    .i_Enable(i_Enable),
    .i_Req   (i_Req),
    .i_Wide  (i_Wide),
    .i_Addr  (i_Addr),
    .i_Data  (i_Data),
    .o_Gnt   (o_Gnt),
    .o_WrEn  (o_WrEn),
    .o_WrHi  (o_WrHi),
    .o_WrLo  (o_WrLo),
    .o_Busy  (o_Busy)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic w, input logic [2:0] a, input logic [15:0] d);
    i_Wide[k] = w;
    i_Addr[3*k +: 3] = a;
    i_Data[16*k +: 16] = d;
  endtask

  always @(negedge i_Clk)
    if (o_Gnt != 3'b000) begin
      if (q.size() == 0) chk("unexpected_gnt", {29'd0, o_Gnt}, 32'd0);
      else begin
        e = q.pop_front();
        chk("gnt", {29'd0, o_Gnt}, {29'd0, e.g});
        chk("wren", {24'd0, o_WrEn}, {24'd0, e.en});
        chk("wrhi", {24'd0, o_WrHi}, {24'd0, e.hi});
        chk("wrlo", {24'd0, o_WrLo}, {24'd0, e.lo});
      end
    end else chk("wren_idle", {24'd0, o_WrEn}, 32'd0);

  initial begin
    repeat (2) @(negedge i_Clk);
    chk("rst_gnt", {29'd0, o_Gnt}, 32'd0);
    chk("rst_wren", {24'd0, o_WrEn}, 32'd0);
    chk("rst_hi", {24'd0, o_WrHi}, 32'd0);
    chk("rst_lo", {24'd0, o_WrLo}, 32'd0);
    chk("rst_busy", {31'd0, o_Busy}, 32'd0);
    step();
    i_nRst = 1'b1;
    // narrow ALU write to B
    set_req(0, 1'b0, 3'd0, 16'h0042);
    i_Req = 3'b001;
    q.push_back('{3'b001, 8'h01, 8'h42, 8'h42});
    step();
    i_Req = 3'b000;
    chk("busy_set", {31'd0, o_Busy}, 32'd1);
    step();
    chk("wren_pulse", {24'd0, o_WrEn}, 32'd0);
    chk("busy_clr", {31'd0, o_Busy}, 32'd0);
    // wide AF write from IDU, F nibble masked
    set_req(2, 1'b1, 3'd6, 16'h12FF);
    i_Req = 3'b100;
    q.push_back('{3'b100, 8'hC0, 8'h12, 8'hF0});
    step();
    i_Req = 3'b000;
    step();
    // narrow write to F from ALU
    set_req(0, 1'b0, 3'd7, 16'h00AB);
    i_Req = 3'b001;
    q.push_back('{3'b001, 8'h80, 8'hAB, 8'hA0});
    step();
    i_Req = 3'b000;
    step();
    // wide write with odd index selects DE
    set_req(1, 1'b1, 3'd3, 16'h3456);
    i_Req = 3'b010;
    q.push_back('{3'b010, 8'h0C, 8'h34, 8'h56});
    step();
    i_Req = 3'b000;
    step();
    // reset, then all three requesting continuously
    i_nRst = 1'b0;
    step();
    i_nRst = 1'b1;
    set_req(0, 1'b0, 3'd1, 16'h0011);
    set_req(1, 1'b0, 3'd2, 16'h0022);
    set_req(2, 1'b0, 3'd5, 16'h0033);
    i_Req = 3'b111;
    q.push_back('{3'b001, 8'h02, 8'h11, 8'h11});
    q.push_back('{3'b010, 8'h04, 8'h22, 8'h22});
    q.push_back('{3'b100, 8'h20, 8'h33, 8'h33});
    q.push_back('{3'b001, 8'h02, 8'h11, 8'h11});
    repeat (4) step();
    // requester 1 re-requests while 0 and 2 stay pending
    q.push_back('{3'b010, 8'h04, 8'h22, 8'h22});
    q.push_back('{3'b100, 8'h20, 8'h33, 8'h33});
    q.push_back('{3'b001, 8'h02, 8'h11, 8'h11});
    q.push_back('{3'b010, 8'h04, 8'h22, 8'h22});
    repeat (4) step();
    i_Req = 3'b000;
    step();
    // enable low: no grants, data and busy hold
    i_Enable = 1'b0;
    i_Req = 3'b100;
    repeat (3) begin
      step();
      chk("dis_gnt", {29'd0, o_Gnt}, 32'd0);
      chk("dis_wren", {24'd0, o_WrEn}, 32'd0);
      chk("dis_hi_hold", {24'd0, o_WrHi}, 32'h22);
      chk("dis_busy_hold", {31'd0, o_Busy}, 32'd0);
    end
    i_Enable = 1'b1;
    q.push_back('{3'b100, 8'h20, 8'h33, 8'h33});
    step();
    i_Req = 3'b000;
    chk("reen_busy", {31'd0, o_Busy}, 32'd1);
    step();
    // async reset during the grant cycle kills the write and resets the pointer
    i_Req = 3'b010;
    step();
    i_Req = 3'b011;
    #1 i_nRst = 1'b0;
    #1;
    chk("arst_gnt", {29'd0, o_Gnt}, 32'd0);
    chk("arst_wren", {24'd0, o_WrEn}, 32'd0);
    chk("arst_hi", {24'd0, o_WrHi}, 32'd0);
    step();
    i_nRst = 1'b1;
    q.push_back('{3'b001, 8'h02, 8'h11, 8'h11});
    step();
    i_Req = 3'b010;
    q.push_back('{3'b010, 8'h04, 8'h22, 8'h22});
    step();
    i_Req = 3'b000;
    repeat (2) step();
    chk("queue_empty", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
